// File: rtl/ren_map_freelist.sv
// Rename stage: maps one instruction per cycle through the speculative RAT, allocates
// a free physical dest, keeps the retirement map and restores the RAT from it on flush.
module ren_map_freelist #(
    parameter  int unsigned ARCH_REGS    = 32,
    parameter  int unsigned PHYS_REGS    = 64,
    parameter  int unsigned PREG_BITS    = 6,
    parameter  int unsigned ROB_PTR_BITS = 6,
    localparam int unsigned AREG_BITS    = $clog2(ARCH_REGS),
    localparam int unsigned CNT_BITS     = $clog2(PHYS_REGS + 1)
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    FREEZE,
    input  logic                    FLUSH_IN,
    input  logic                    ID_valid_IN,
    input  logic [AREG_BITS-1:0]    ID_src1_IN,
    input  logic [AREG_BITS-1:0]    ID_src2_IN,
    input  logic [AREG_BITS-1:0]    ID_dest_IN,
    input  logic                    ID_needDest_IN,
    input  logic                    ID_isMem_IN,
    input  logic                    IQ_full_IN,
    input  logic                    LSQ_full_IN,
    input  logic                    COM_valid_IN,
    input  logic [AREG_BITS-1:0]    COM_archDest_IN,
    input  logic [PREG_BITS-1:0]    COM_newPhys_IN,
    input  logic [PREG_BITS-1:0]    COM_oldPhys_IN,
    output logic                    ID_stall_OUT,
    output logic                    REN_valid_OUT,
    output logic                    REN_toLSQ_OUT,
    output logic [PREG_BITS-1:0]    REN_src1Phys_OUT,
    output logic [PREG_BITS-1:0]    REN_src2Phys_OUT,
    output logic [PREG_BITS-1:0]    REN_destPhys_OUT,
    output logic [PREG_BITS-1:0]    REN_oldPhys_OUT,
    output logic [ROB_PTR_BITS-1:0] REN_robPtr_OUT,
    output logic [CNT_BITS-1:0]     REN_freeCount_OUT
);

    logic [PREG_BITS-1:0]    rat_q  [ARCH_REGS];
    logic [PREG_BITS-1:0]    rat_d  [ARCH_REGS];
    logic [PREG_BITS-1:0]    rrat_q [ARCH_REGS];
    logic [PREG_BITS-1:0]    rrat_d [ARCH_REGS];
    logic [PHYS_REGS-1:0]    free_q, free_d;
    logic [PHYS_REGS-1:0]    ref_mask;
    logic [CNT_BITS-1:0]     cnt_q, cnt_d;
    logic [ROB_PTR_BITS-1:0] rob_q, rob_d;

    logic                    valid_q, valid_d;
    logic                    to_lsq_q, to_lsq_d;
    logic [PREG_BITS-1:0]    src1_q, src1_d;
    logic [PREG_BITS-1:0]    src2_q, src2_d;
    logic [PREG_BITS-1:0]    dest_q, dest_d;
    logic [PREG_BITS-1:0]    old_q, old_d;
    logic [ROB_PTR_BITS-1:0] rob_out_q, rob_out_d;

    logic [PREG_BITS-1:0]    alloc_idx;
    logic                    need_alloc;
    logic                    queue_full;
    logic                    stall_c;
    logic                    accept;
    logic                    commit;

    // Lowest-index free physical register.
    always_comb begin
        alloc_idx = '0;
        for (int i = int'(PHYS_REGS) - 1; i >= 0; i--) begin
            if (free_q[i]) begin
                alloc_idx = PREG_BITS'(i);
            end
        end
    end

    // Arch r0 is hardwired to phys 0, so a dest of r0 never allocates.
    always_comb begin
        need_alloc = ID_needDest_IN & (ID_dest_IN != '0);
        queue_full = ID_isMem_IN ? LSQ_full_IN : IQ_full_IN;
        stall_c    = FREEZE | queue_full | (need_alloc & (cnt_q == '0));
        accept     = ID_valid_IN & ~stall_c & ~FLUSH_IN;
        commit     = COM_valid_IN & ~FREEZE & (COM_archDest_IN != '0);
    end

    assign ID_stall_OUT = stall_c;

    always_comb begin
        rat_d     = rat_q;
        rrat_d    = rrat_q;
        free_d    = free_q;
        rob_d     = rob_q;
        ref_mask  = '0;
        valid_d   = valid_q;
        to_lsq_d  = to_lsq_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        dest_d    = dest_q;
        old_d     = old_q;
        rob_out_d = rob_out_q;

        if (!FREEZE) begin
            valid_d = 1'b0;
            if (commit) begin
                rrat_d[COM_archDest_IN] = COM_newPhys_IN;
                if (COM_oldPhys_IN != '0) begin
                    free_d[COM_oldPhys_IN] = 1'b1;
                end
            end
            // Flush rebuilds the free list from whatever the post-commit RRAT references.
            if (FLUSH_IN) begin
                for (int i = 0; i < int'(ARCH_REGS); i++) begin
                    ref_mask[rrat_d[i]] = 1'b1;
                end
                rat_d  = rrat_d;
                free_d = ~ref_mask;
                rob_d  = '0;
            end else if (accept) begin
                valid_d   = 1'b1;
                to_lsq_d  = ID_isMem_IN;
                src1_d    = rat_q[ID_src1_IN];
                src2_d    = rat_q[ID_src2_IN];
                rob_out_d = rob_q;
                rob_d     = rob_q + ROB_PTR_BITS'(1);
                if (need_alloc) begin
                    dest_d                = alloc_idx;
                    old_d                 = rat_q[ID_dest_IN];
                    rat_d[ID_dest_IN]     = alloc_idx;
                    free_d[alloc_idx]     = 1'b0;
                end else begin
                    dest_d = '0;
                    old_d  = '0;
                end
            end
        end
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < int'(PHYS_REGS); i++) begin
            cnt_d = cnt_d + CNT_BITS'(free_d[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int i = 0; i < int'(ARCH_REGS); i++) begin
                rat_q[i]  <= PREG_BITS'(i);
                rrat_q[i] <= PREG_BITS'(i);
            end
            for (int i = 0; i < int'(PHYS_REGS); i++) begin
                free_q[i] <= (i >= int'(ARCH_REGS));
            end
            cnt_q     <= CNT_BITS'(PHYS_REGS - ARCH_REGS);
            rob_q     <= '0;
            valid_q   <= 1'b0;
            to_lsq_q  <= 1'b0;
            src1_q    <= '0;
            src2_q    <= '0;
            dest_q    <= '0;
            old_q     <= '0;
            rob_out_q <= '0;
        end else begin
            rat_q     <= rat_d;
            rrat_q    <= rrat_d;
            free_q    <= free_d;
            cnt_q     <= cnt_d;
            rob_q     <= rob_d;
            valid_q   <= valid_d;
            to_lsq_q  <= to_lsq_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            dest_q    <= dest_d;
            old_q     <= old_d;
            rob_out_q <= rob_out_d;
        end
    end

    assign REN_valid_OUT     = valid_q;
    assign REN_toLSQ_OUT     = to_lsq_q;
    assign REN_src1Phys_OUT  = src1_q;
    assign REN_src2Phys_OUT  = src2_q;
    assign REN_destPhys_OUT  = dest_q;
    assign REN_oldPhys_OUT   = old_q;
    assign REN_robPtr_OUT    = rob_out_q;
    assign REN_freeCount_OUT = cnt_q;

endmodule

// File: tb/tb_ren_map_freelist.sv
// Directed bench for ren_map_freelist: a vector table plus hand-built sequences for
// free-list exhaustion and flush-with-commit recovery.
module tb_ren_map_freelist;

    logic       CLK;
    logic       RESET;
    logic       FREEZE;
    logic       FLUSH_IN;
    logic       ID_valid_IN;
    logic [4:0] ID_src1_IN;
    logic [4:0] ID_src2_IN;
    logic [4:0] ID_dest_IN;
    logic       ID_needDest_IN;
    logic       ID_isMem_IN;
    logic       IQ_full_IN;
    logic       LSQ_full_IN;
    logic       COM_valid_IN;
    logic [4:0] COM_archDest_IN;
    logic [5:0] COM_newPhys_IN;
    logic [5:0] COM_oldPhys_IN;
    logic       ID_stall_OUT;
    logic       REN_valid_OUT;
    logic       REN_toLSQ_OUT;
    logic [5:0] REN_src1Phys_OUT;
    logic [5:0] REN_src2Phys_OUT;
    logic [5:0] REN_destPhys_OUT;
    logic [5:0] REN_oldPhys_OUT;
    logic [5:0] REN_robPtr_OUT;
    logic [6:0] REN_freeCount_OUT;

    ren_map_freelist dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .FREEZE            (FREEZE),
        .FLUSH_IN          (FLUSH_IN),
        .ID_valid_IN       (ID_valid_IN),
        .ID_src1_IN        (ID_src1_IN),
        .ID_src2_IN        (ID_src2_IN),
        .ID_dest_IN        (ID_dest_IN),
        .ID_needDest_IN    (ID_needDest_IN),
        .ID_isMem_IN       (ID_isMem_IN),
        .IQ_full_IN        (IQ_full_IN),
        .LSQ_full_IN       (LSQ_full_IN),
        .COM_valid_IN      (COM_valid_IN),
        .COM_archDest_IN   (COM_archDest_IN),
        .COM_newPhys_IN    (COM_newPhys_IN),
        .COM_oldPhys_IN    (COM_oldPhys_IN),
        .ID_stall_OUT      (ID_stall_OUT),
        .REN_valid_OUT     (REN_valid_OUT),
        .REN_toLSQ_OUT     (REN_toLSQ_OUT),
        .REN_src1Phys_OUT  (REN_src1Phys_OUT),
        .REN_src2Phys_OUT  (REN_src2Phys_OUT),
        .REN_destPhys_OUT  (REN_destPhys_OUT),
        .REN_oldPhys_OUT   (REN_oldPhys_OUT),
        .REN_robPtr_OUT    (REN_robPtr_OUT),
        .REN_freeCount_OUT (REN_freeCount_OUT)
    );

    typedef struct {
        int rst, vld, s1, s2, d, nd, mem;
        int iqf, lsqf, frz, fl;
        int cv, ca, cn, co;
        int e_stall, e_vld, e_lsq, e_s1, e_s2, e_d, e_o, e_rob, e_cnt, chk;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl [16];
    vec_t v;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive at a falling edge, check stall before the rising edge, outputs at the next falling edge.
    task automatic apply(input vec_t x, input string tag);
        RESET           = (x.rst != 0) ? 1'b0 : 1'b1;
        ID_valid_IN     = 1'(x.vld);
        ID_src1_IN      = 5'(x.s1);
        ID_src2_IN      = 5'(x.s2);
        ID_dest_IN      = 5'(x.d);
        ID_needDest_IN  = 1'(x.nd);
        ID_isMem_IN     = 1'(x.mem);
        IQ_full_IN      = 1'(x.iqf);
        LSQ_full_IN     = 1'(x.lsqf);
        FREEZE          = 1'(x.frz);
        FLUSH_IN        = 1'(x.fl);
        COM_valid_IN    = 1'(x.cv);
        COM_archDest_IN = 5'(x.ca);
        COM_newPhys_IN  = 6'(x.cn);
        COM_oldPhys_IN  = 6'(x.co);
        #1;
        check({tag, ".stall"}, int'(ID_stall_OUT), x.e_stall);
        @(negedge CLK);
        check({tag, ".valid"}, int'(REN_valid_OUT), x.e_vld);
        check({tag, ".freeCount"}, int'(REN_freeCount_OUT), x.e_cnt);
        if (x.chk != 0) begin
            check({tag, ".toLSQ"}, int'(REN_toLSQ_OUT), x.e_lsq);
            check({tag, ".src1"}, int'(REN_src1Phys_OUT), x.e_s1);
            check({tag, ".src2"}, int'(REN_src2Phys_OUT), x.e_s2);
            check({tag, ".dest"}, int'(REN_destPhys_OUT), x.e_d);
            check({tag, ".old"}, int'(REN_oldPhys_OUT), x.e_o);
            check({tag, ".robPtr"}, int'(REN_robPtr_OUT), x.e_rob);
        end
    endtask

    initial begin
        //          rst vld s1 s2  d nd mem iqf lsqf frz fl  cv ca cn co  stall vld lsq s1 s2  d  o rob cnt chk
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 32, 1};
        tbl[1]  = '{0, 1, 1, 2, 5, 1, 0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 1, 0, 1, 2, 32, 5, 0, 31, 1};
        tbl[2]  = '{1, 1, 1, 0, 7, 1, 0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 32, 1};
        tbl[3]  = '{0, 1, 5, 1, 5, 1, 0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 1, 0, 5, 1, 32, 5, 0, 31, 1};
        tbl[4]  = '{0, 1, 5, 1, 5, 1, 0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 1, 0, 32, 1, 33, 32, 1, 30, 1};
        tbl[5]  = '{0, 1, 1, 1, 6, 1, 1,  0, 1, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 30, 0};
        tbl[6]  = '{0, 1, 0, 5, 6, 1, 0,  0, 1, 0, 0,  0, 0, 0, 0,  0, 1, 0, 0, 33, 34, 6, 2, 29, 1};
        tbl[7]  = '{0, 1, 6, 0, 0, 1, 1,  1, 0, 0, 0,  0, 0, 0, 0,  0, 1, 1, 34, 0, 0, 0, 3, 29, 1};
        tbl[8]  = '{0, 1, 1, 1, 9, 1, 0,  1, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 29, 0};
        tbl[9]  = '{0, 1, 1, 1, 7, 1, 0,  0, 0, 0, 1,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 32, 0};
        tbl[10] = '{0, 1, 5, 6, 5, 1, 0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 1, 0, 5, 6, 32, 5, 0, 31, 1};
        tbl[11] = '{0, 1, 5, 9, 8, 1, 0,  0, 0, 1, 0,  1, 9, 40, 9, 1, 1, 0, 5, 6, 32, 5, 0, 31, 1};
        tbl[12] = tbl[11];
        tbl[13] = tbl[11];
        tbl[14] = '{0, 1, 5, 9, 8, 1, 0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 1, 0, 32, 9, 33, 8, 1, 30, 1};
        tbl[15] = '{1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 32, 1};

        RESET = 1'b0; FREEZE = 1'b0; FLUSH_IN = 1'b0; ID_valid_IN = 1'b0;
        ID_src1_IN = '0; ID_src2_IN = '0; ID_dest_IN = '0; ID_needDest_IN = 1'b0;
        ID_isMem_IN = 1'b0; IQ_full_IN = 1'b0; LSQ_full_IN = 1'b0; COM_valid_IN = 1'b0;
        COM_archDest_IN = '0; COM_newPhys_IN = '0; COM_oldPhys_IN = '0;
        @(negedge CLK);
        @(negedge CLK);

        for (int i = 0; i < 16; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Exhaust the free list (reset left by the last vector), r1..r31 then r1 again.
        for (int k = 0; k < 32; k++) begin
            v = '{default: 0};
            v.vld = 1; v.nd = 1; v.d = (k % 31) + 1;
            v.e_vld = 1; v.e_d = 32 + k; v.e_o = (k < 31) ? k + 1 : 32;
            v.e_rob = k; v.e_cnt = 31 - k; v.chk = 1;
            apply(v, $sformatf("alloc%0d", k));
        end
        v = '{default: 0};
        v.vld = 1; v.s1 = 1; v.d = 2; v.nd = 0;
        v.e_vld = 1; v.e_s1 = 63; v.e_rob = 32; v.e_cnt = 0; v.chk = 1;
        apply(v, "nodest_empty");
        v = '{default: 0};
        v.vld = 1; v.d = 3; v.nd = 1; v.cv = 1; v.ca = 5; v.cn = 36; v.co = 5;
        v.e_stall = 1; v.e_vld = 0; v.e_cnt = 1;
        apply(v, "stall_empty");
        v = '{default: 0};
        v.vld = 1; v.d = 3; v.nd = 1;
        v.e_vld = 1; v.e_d = 5; v.e_o = 34; v.e_rob = 33; v.e_cnt = 0; v.chk = 1;
        apply(v, "reuse_freed");
        v = '{default: 0};
        v.vld = 1; v.s1 = 3; v.d = 0; v.nd = 1;
        v.e_vld = 1; v.e_s1 = 5; v.e_rob = 34; v.e_cnt = 0; v.chk = 1;
        apply(v, "r0dest_empty");

        // Flush with a same-cycle commit: RRAT r3->32 must survive into the restored RAT.
        v = '{default: 0}; v.rst = 1; v.e_cnt = 32; v.chk = 1;
        apply(v, "reset2");
        v = '{default: 0}; v.vld = 1; v.d = 3; v.nd = 1;
        v.e_vld = 1; v.e_d = 32; v.e_o = 3; v.e_rob = 0; v.e_cnt = 31; v.chk = 1;
        apply(v, "ren_r3");
        v = '{default: 0}; v.vld = 1; v.d = 4; v.nd = 1;
        v.e_vld = 1; v.e_d = 33; v.e_o = 4; v.e_rob = 1; v.e_cnt = 30; v.chk = 1;
        apply(v, "ren_r4");
        v = '{default: 0}; v.fl = 1; v.cv = 1; v.ca = 3; v.cn = 32; v.co = 3;
        v.e_vld = 0; v.e_cnt = 32;
        apply(v, "flush_commit");
        v = '{default: 0}; v.vld = 1; v.s1 = 3; v.s2 = 4; v.d = 10; v.nd = 1;
        v.e_vld = 1; v.e_s1 = 32; v.e_s2 = 4; v.e_d = 3; v.e_o = 10; v.e_rob = 0; v.e_cnt = 31; v.chk = 1;
        apply(v, "post_flush1");
        v = '{default: 0}; v.vld = 1; v.d = 11; v.nd = 1;
        v.e_vld = 1; v.e_d = 33; v.e_o = 11; v.e_rob = 1; v.e_cnt = 30; v.chk = 1;
        apply(v, "post_flush2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
